// File: rtl/bcd_time_loader_pkg.sv
// Shared definitions for the BCD time loader slice.
//   BCD_W     : bits per BCD digit
//   SECONDS_W : width of the seconds count, shared with the counter and display path
//   state_t   : loader FSM states
package bcd_time_loader_pkg;

    localparam int BCD_W     = 4;
    localparam int SECONDS_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_LOAD
    } state_t;

endpackage

// File: rtl/bcd_time_loader_mac10.sv
// bcd_mac10: combinational multiply-by-ten accumulate, out = in*10 + d.
// Built from two shifts and adds, so no multiplier is inferred.
// Ports:
//   in  [WIDTH-1:0]  running accumulator
//   d   [BCD_W-1:0]  next decimal digit (0..9)
//   out [WIDTH-1:0]  in*10 + d, truncated modulo 2^WIDTH
module bcd_mac10
    import bcd_time_loader_pkg::*;
#(
    parameter int WIDTH = SECONDS_W
) (
    input  logic [WIDTH-1:0] in,
    input  logic [BCD_W-1:0] d,
    output logic [WIDTH-1:0] out
);

    // in*10 == in*8 + in*2
    assign out = (in << 3) + (in << 1) + WIDTH'(d);

endmodule

// File: rtl/bcd_time_loader.sv
// bcd_time_loader: converts DIGITS operator-entered BCD digits (MSD first) into a
// binary seconds value and loads it into the seconds counter, one digit per clock.
// Ports:
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   start       conversion request, sampled only in IDLE
//   digits      BCD digits, MSD in the top nibble
//   busy        high while converting or loading
//   done        one-cycle pulse, load_value is new
//   err         one-cycle pulse, start rejected because a nibble was > 9
//   load_value  binary result to the counter load input
//   load_n      active-low one-cycle load strobe to the counter
module bcd_time_loader
    import bcd_time_loader_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int WIDTH  = SECONDS_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [WIDTH-1:0]        load_value,
    output logic                    load_n
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [BCD_W*DIGITS-1:0] shreg;
    logic [WIDTH-1:0]        acc;
    logic [WIDTH-1:0]        mac_out;
    logic [IDX_W-1:0]        idx;
    logic                    digits_ok;
    logic                    last_digit;
    logic                    accept;
    logic                    done_next;
    logic                    err_next;
    logic                    load_n_next;

    always_comb begin
        digits_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits[i*BCD_W +: BCD_W] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    assign accept     = (state == ST_IDLE) && start && digits_ok;
    assign last_digit = (idx == IDX_W'(DIGITS - 1));
    assign busy       = (state != ST_IDLE);

    bcd_mac10 #(
        .WIDTH(WIDTH)
    ) u_mac10 (
        .in (acc),
        .d  (shreg[BCD_W*DIGITS-1 -: BCD_W]),
        .out(mac_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (accept) state_next = ST_CONVERT;
            ST_CONVERT: if (last_digit) state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decode; the strobes are registered below, so they appear the
    // cycle after LOAD is entered and drop one cycle later.
    always_comb begin
        done_next   = (state == ST_LOAD);
        load_n_next = (state != ST_LOAD);
        err_next    = (state == ST_IDLE) && start && !digits_ok;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg      <= '0;
            acc        <= '0;
            idx        <= '0;
            load_value <= '0;
            load_n     <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done   <= done_next;
            err    <= err_next;
            load_n <= load_n_next;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= digits;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                ST_CONVERT: begin
                    acc   <= mac_out;
                    shreg <= shreg << BCD_W;
                    idx   <= idx + IDX_W'(1);
                end
                ST_LOAD: begin
                    load_value <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Testbench for bcd_time_loader: directed vectors, scoreboard queue of expected
// done/err events checked by an independent negedge monitor.
module tb_bcd_time_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] digits;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] load_value;
    logic        load_n;

    typedef struct {
        bit          is_err;
        logic [63:0] value;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        done_prev = 1'b0;
    logic [63:0] last_good = '0;

    bcd_time_loader #(
        .DIGITS(8),
        .WIDTH (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .digits    (digits),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_value(load_value),
        .load_n    (load_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops and compares whenever the DUT presents done or err.
    always @(negedge clk) begin
        exp_t e;
        if (done || err) begin
            if (sb.size() == 0) begin
                check(done ? "unexpected_done" : "unexpected_err", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {63'd0, err}, {63'd0, e.is_err});
                check("event_cycle", 64'(cyc), 64'(e.cyc));
                check("load_value", load_value, e.value);
                if (e.is_err) begin
                    check("err_busy", {63'd0, busy}, 64'd0);
                    check("err_load_n", {63'd0, load_n}, 64'd1);
                end else begin
                    check("done_width", {63'd0, done_prev}, 64'd0);
                end
            end
        end
        if (done || !load_n) begin
            check("load_n_vs_done", {63'd0, load_n}, {63'd0, ~done});
        end
        done_prev <= done;
    end

    // Issue one start pulse; expected event pushed before the accepting edge.
    task automatic issue(input logic [31:0] d, input bit is_err, input logic [63:0] value);
        exp_t e;
        digits = d;
        start  = 1'b1;
        e.is_err = is_err;
        e.value  = is_err ? last_good : value;
        e.cyc    = is_err ? cyc + 1 : cyc + 10;
        if (!is_err) last_good = value;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        digits  = '0;
        repeat (3) @(negedge clk);
        check("rst_load_value", load_value, 64'd0);
        check("rst_load_n", {63'd0, load_n}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic conversion
        issue(32'h12345678, 1'b0, 64'd12345678);
        check("busy_convert", {63'd0, busy}, 64'd1);
        drain();
        check("busy_after", {63'd0, busy}, 64'd0);

        // Extremes
        issue(32'h99999999, 1'b0, 64'd99999999);
        drain();
        issue(32'h00000000, 1'b0, 64'd0);
        drain();
        issue(32'h31536000, 1'b0, 64'd31536000);
        drain();

        // Invalid nibble: err pulse, load_value keeps 31536000
        issue(32'h1234A678, 1'b1, 64'd0);
        drain();
        check("hold_after_err", load_value, 64'd31536000);
        issue(32'hF0000000, 1'b1, 64'd0);
        drain();

        // start during CONVERT is ignored; digits changing later have no effect
        issue(32'h20240101, 1'b0, 64'd20240101);
        repeat (2) @(negedge clk);
        digits = 32'h87654321;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        digits = 32'h11111111;
        drain();

        // Reset at edge 4 of a conversion aborts it with no load strobe
        digits  = 32'h55555555;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_load_value", load_value, 64'd0);
        check("abort_load_n", {63'd0, load_n}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_err", {63'd0, err}, 64'd0);
        reset_n   = 1'b1;
        last_good = '0;
        repeat (12) @(negedge clk);
        issue(32'h00086399, 1'b0, 64'd86399);
        drain();

        // start held high: accepts at edges E, E+10, E+20
        begin
            exp_t e;
            digits = 32'h00000042;
            start  = 1'b1;
            for (int k = 0; k < 3; k++) begin
                e.is_err = 1'b0;
                e.value  = 64'd42;
                e.cyc    = cyc + 10 + 10 * k;
                sb.push_back(e);
            end
            repeat (21) @(negedge clk);
            start = 1'b0;
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
